// File: rtl/conv3x3_mac_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv3x3_mac_stage: 3x3 signed Q8.8 MAC with bias, round, saturate.     |
// | Optional ReLU on the output via CONV3X3_RELU_EN. Revision 1.0          |
// +------------------------------------------------------------------------+
module conv3x3_mac_stage #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_start,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  input  logic              win_valid,
  input  logic [DATA_W-1:0] win0,
  input  logic [DATA_W-1:0] win1,
  input  logic [DATA_W-1:0] win2,
  input  logic [DATA_W-1:0] win3,
  input  logic [DATA_W-1:0] win4,
  input  logic [DATA_W-1:0] win5,
  input  logic [DATA_W-1:0] win6,
  input  logic [DATA_W-1:0] win7,
  input  logic [DATA_W-1:0] win8,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  output logic              kernel_ready,
  output logic              drop_err,
  output logic [15:0]       pix_count
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int NWORDS = 10;
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] idx, idx_next, wr_slot;
  logic       wr_en, commit;

  logic signed [DATA_W-1:0] shadow [NWORDS];
  logic signed [DATA_W-1:0] kern [9];
  logic signed [DATA_W-1:0] bias_act;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // ---------------- weight load FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    wr_en      = 1'b0;
    wr_slot    = idx;
    commit     = (state == COMMIT);
    if (state == COMMIT) begin
      state_next = IDLE;
      idx_next   = '0;
    end
    // w_start wins over everything, including a pending commit's index reset
    if (w_start) begin
      state_next = LOAD;
      wr_slot    = '0;
      wr_en      = w_valid;
      idx_next   = w_valid ? 4'd1 : 4'd0;
    end else if (w_valid && state != COMMIT) begin
      wr_en = 1'b1;
      if (idx == 4'(NWORDS - 1)) begin
        state_next = COMMIT;
        idx_next   = '0;
      end else begin
        state_next = LOAD;
        idx_next   = idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) shadow[i] <= '0;
      for (int i = 0; i < 9; i++) kern[i] <= '0;
      bias_act     <= '0;
      kernel_ready <= 1'b0;
    end else begin
      if (wr_en) shadow[wr_slot] <= w_data;
      if (commit) begin
        for (int i = 0; i < 9; i++) kern[i] <= shadow[i];
        bias_act     <= shadow[NWORDS-1];
        kernel_ready <= 1'b1;
      end
    end
  end

  // ---------------- MAC pipeline ----------------
  logic signed [DATA_W-1:0] win [9];
  assign win[0] = win0;
  assign win[1] = win1;
  assign win[2] = win2;
  assign win[3] = win3;
  assign win[4] = win4;
  assign win[5] = win5;
  assign win[6] = win6;
  assign win[7] = win7;
  assign win[8] = win8;

  logic accept;
  assign accept = win_valid & kernel_ready;

  logic signed [PROD_W-1:0] prod [9];
  logic signed [DATA_W-1:0] s1_bias, s2_bias;
  logic                     s1_valid, s2_valid;
  logic signed [ACC_W-1:0]  row [3];

  // Bias travels with its window so a commit never mixes kernel sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bias  <= '0;
      for (int i = 0; i < 9; i++) prod[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        for (int i = 0; i < 9; i++) prod[i] <= win[i] * kern[i];
        s1_bias <= bias_act;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_bias  <= '0;
      for (int r = 0; r < 3; r++) row[r] <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int r = 0; r < 3; r++)
          row[r] <= sext_prod(prod[3*r]) + sext_prod(prod[3*r+1]) + sext_prod(prod[3*r+2]);
        s2_bias <= s1_bias;
      end
    end
  end

  logic signed [ACC_W-1:0]  bias_ext, total, rounded;
  logic signed [DATA_W-1:0] sat_val, result;

  always_comb begin
    bias_ext = {{(ACC_W-DATA_W){s2_bias[DATA_W-1]}}, s2_bias};
    total    = row[0] + row[1] + row[2] + (bias_ext <<< FRAC_W) + RND;
    rounded  = total >>> FRAC_W;
    if (rounded > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (rounded < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = rounded[DATA_W-1:0];
`ifdef CONV3X3_RELU_EN
    result = sat_val[DATA_W-1] ? '0 : sat_val;
`else
    result = sat_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
      pix_count <= '0;
      drop_err  <= 1'b0;
    end else begin
      pix_valid <= s2_valid;
      if (s2_valid) begin
        pix_out   <= result;
        pix_count <= pix_count + 16'd1;
      end
      if (win_valid && !kernel_ready) drop_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_mac_stage.sv
`default_nettype none
// Bench for conv3x3_mac_stage: directed windows/loads, per-cycle comparison
// against an arithmetic model, plus literal pixel expectations.
module tb_conv3x3_mac_stage;

`ifdef CONV3X3_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, w_start = 1'b0, w_valid = 1'b0, win_valid = 1'b0;
  logic [15:0] w_data = '0;
  logic [15:0] win [9];
  logic [15:0] pix_out, pix_count;
  logic        pix_valid, kernel_ready, drop_err;

  conv3x3_mac_stage dut (
    .clk(clk), .rst(rst), .w_start(w_start), .w_valid(w_valid), .w_data(w_data),
    .win_valid(win_valid),
    .win0(win[0]), .win1(win[1]), .win2(win[2]), .win3(win[3]), .win4(win[4]),
    .win5(win[5]), .win6(win[6]), .win7(win[7]), .win8(win[8]),
    .pix_out(pix_out), .pix_valid(pix_valid), .kernel_ready(kernel_ready),
    .drop_err(drop_err), .pix_count(pix_count)
  );

  int vectors = 0, errors = 0;
  int n = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s (edge %0d): got %h, want %h", name, n, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_shadow [10];
  logic [15:0] m_act [9];
  logic [15:0] m_bias, m_out, m_count, cur_d;
  int          m_idx;
  bit          m_pending, m_ready, m_drop, cur_v;
  bit          exp_v [1024];
  logic [15:0] exp_d [1024];

  function automatic logic [15:0] model_pix();
    longint acc = 0;
    for (int i = 0; i < 9; i++) acc += longint'($signed(win[i])) * longint'($signed(m_act[i]));
    acc += longint'($signed(m_bias)) * 256 + 128;
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (RELU && acc < 0) acc = 0;
    return acc[15:0];
  endfunction

  task automatic model_step();
    bit pend_old;
    n++;
    cur_v = exp_v[n % 1024];
    cur_d = exp_d[n % 1024];
    exp_v[n % 1024] = 1'b0;
    if (rst) begin
      cur_v = 1'b0;
      exp_v[(n + 1) % 1024] = 1'b0;
      m_out = '0; m_count = '0; m_ready = 1'b0; m_drop = 1'b0;
      m_idx = 0; m_pending = 1'b0; m_bias = '0;
      for (int i = 0; i < 10; i++) m_shadow[i] = '0;
      for (int i = 0; i < 9; i++) m_act[i] = '0;
    end else begin
      if (cur_v) begin m_out = cur_d; m_count++; end
      if (win_valid) begin
        if (m_ready) begin
          exp_v[(n + 2) % 1024] = 1'b1;
          exp_d[(n + 2) % 1024] = model_pix();
        end else m_drop = 1'b1;
      end
      pend_old = m_pending;
      if (m_pending) begin
        for (int i = 0; i < 9; i++) m_act[i] = m_shadow[i];
        m_bias = m_shadow[9]; m_ready = 1'b1; m_pending = 1'b0;
      end
      if (w_start) m_idx = 0;
      if (w_valid && (w_start || !pend_old)) begin
        m_shadow[m_idx] = w_data;
        m_idx++;
        if (m_idx == 10) begin m_idx = 0; m_pending = 1'b1; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  typedef struct { int e; logic [15:0] d; } obs_t;
  obs_t obs_q[$];

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("pix_valid", {31'b0, pix_valid}, {31'b0, cur_v});
      check("pix_out", {16'b0, pix_out}, {16'b0, m_out});
      check("pix_count", {16'b0, pix_count}, {16'b0, m_count});
      check("kernel_ready", {31'b0, kernel_ready}, {31'b0, m_ready});
      check("drop_err", {31'b0, drop_err}, {31'b0, m_drop});
      if (pix_valid) obs_q.push_back('{n, pix_out});
    end
  end

  // ---------------- directed stimulus ----------------
  int last_e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pix(input string name, input logic [15:0] val);
    obs_t o;
    check({name, " present"}, {31'b0, obs_q.size() > 0}, 32'd1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check(name, {16'b0, o.d}, {16'b0, val});
      last_e = o.e;
    end
  endtask

  task automatic load(input logic [15:0] kv, input logic [15:0] b);
    for (int i = 0; i < 10; i++) begin
      w_valid = 1'b1;
      w_data  = (i < 9) ? kv : b;
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic load_center(input logic [15:0] k4, input logic [15:0] b);
    for (int i = 0; i < 10; i++) begin
      w_valid = 1'b1;
      w_data  = (i == 9) ? b : ((i == 4) ? k4 : 16'h0000);
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic put_window(input logic [15:0] centre, input logic [15:0] others);
    for (int i = 0; i < 9; i++) win[i] = others;
    win[4]    = centre;
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
  endtask

  int t0;

  initial begin
    for (int i = 0; i < 9; i++) win[i] = '0;
    tick();
    checking = 1'b1;
    tick();
    rst = 1'b0;
    check("reset pix_out", {16'b0, pix_out}, 32'h0);
    check("reset kernel_ready", {31'b0, kernel_ready}, 32'h0);

    // windows before any kernel are dropped
    repeat (5) put_window(16'h0100, 16'h0100);
    repeat (5) tick();
    check("drop_err set", {31'b0, drop_err}, 32'h1);
    check("no pix on drop", obs_q.size(), 32'h0);
    check("count after drop", {16'b0, pix_count}, 32'h0);

    // identity kernel
    load(16'h0100, 16'h0000);
    check("ready before commit", {31'b0, kernel_ready}, 32'h0);
    tick();
    check("ready after commit", {31'b0, kernel_ready}, 32'h1);
    check("drop_err sticky", {31'b0, drop_err}, 32'h1);
    obs_q.delete();
    t0 = n;
    put_window(16'h0100, 16'h0100);
    repeat (4) tick();
    expect_pix("sum of ones", 16'h0900);
    check("latency", last_e - t0, 32'd3);
    check("count one", {16'b0, pix_count}, 32'h1);

    // bias 0.5; 1/256 * 1.0 survives the shift intact
    load(16'h0100, 16'h0080);
    tick();
    put_window(16'h0001, 16'h0000);
    put_window(16'h0100, 16'h0100);
    repeat (4) tick();
    expect_pix("bias tiny", 16'h0081);
    expect_pix("bias ones", 16'h0980);

    // centre weight 1/256: products sit right at the rounding point
    load_center(16'h0001, 16'h0080);
    tick();
    put_window(16'h0001, 16'h0000);
    put_window(16'h0080, 16'h0000);
    put_window(16'hFF80, 16'h0000);
    put_window(16'hFF7F, 16'h0000);
    repeat (4) tick();
    expect_pix("round below half", 16'h0080);
    expect_pix("round half up", 16'h0081);
    expect_pix("round neg half", 16'h0080);
    expect_pix("round neg below", 16'h007F);

    // saturation and sign
    load(16'h7FFF, 16'h0000);
    tick();
    put_window(16'h7FFF, 16'h7FFF);
    repeat (4) tick();
    expect_pix("sat positive", 16'h7FFF);
    load(16'hFF00, 16'h0000);
    tick();
    put_window(16'h0100, 16'h0100);
    repeat (4) tick();
    expect_pix("minus nine", RELU ? 16'h0000 : 16'hF700);
    load(16'h8000, 16'h0000);
    tick();
    put_window(16'h7FFF, 16'h7FFF);
    put_window(16'h8000, 16'h8000);
    repeat (4) tick();
    expect_pix("sat negative", RELU ? 16'h0000 : 16'h8000);
    expect_pix("sat neg*neg", 16'h7FFF);

    // reload mid-stream: commit edge coincides with window 10
    load(16'h0100, 16'h0000);
    tick();
    obs_q.delete();
    for (int t = 0; t <= 20; t++) begin
      w_valid = (t < 10);
      w_data  = (t < 9) ? 16'h0200 : 16'h0000;
      for (int i = 0; i < 9; i++) win[i] = 16'h0100;
      win_valid = (t >= 1);
      tick();
    end
    w_valid = 1'b0;
    win_valid = 1'b0;
    repeat (4) tick();
    t0 = 0;
    for (int i = 1; i <= 20; i++) begin
      expect_pix("reload stream", (i <= 10) ? 16'h0900 : 16'h1200);
      if (i == 1) t0 = last_e;
      else check("reload no gap", last_e - t0, i - 1);
    end

    // partial load aborted by w_start leaves the active kernel alone
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1;
      w_data  = 16'h0300;
      tick();
    end
    w_valid = 1'b0;
    tick();
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    repeat (2) tick();
    put_window(16'h0100, 16'h0100);
    repeat (4) tick();
    expect_pix("after abort", 16'h1200);
    check("ready after abort", {31'b0, kernel_ready}, 32'h1);
    w_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w_valid = 1'b1;
      w_data  = 16'h0100;
      tick();
      w_start = 1'b0;
    end
    w_valid = 1'b0;
    tick();
    put_window(16'h0100, 16'h0100);
    repeat (4) tick();
    expect_pix("start with word0", 16'h0A00);

    // reset one cycle after a window is accepted
    obs_q.delete();
    put_window(16'h0100, 16'h0100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("no pix after rst", obs_q.size(), 32'h0);
    check("rst pix_out", {16'b0, pix_out}, 32'h0);
    check("rst pix_count", {16'b0, pix_count}, 32'h0);
    check("rst kernel_ready", {31'b0, kernel_ready}, 32'h0);
    check("rst drop_err", {31'b0, drop_err}, 32'h0);
    put_window(16'h0100, 16'h0100);
    tick();
    check("drop after rst", {31'b0, drop_err}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
